// File: rtl/flash_cmd_pkg.sv
// Opcode constants, per-opcode field counts and FSM state encoding shared by the
// SPI flash engine and its opcode lookup.
package flash_cmd_pkg;

  localparam logic [7:0] OP_RDID    = 8'h9F;
  localparam logic [7:0] OP_RDSR1   = 8'h05;
  localparam logic [7:0] OP_RDSR2   = 8'h07;
  localparam logic [7:0] OP_RES     = 8'hAB;
  localparam logic [7:0] OP_RDCR    = 8'h35;
  localparam logic [7:0] OP_WREN    = 8'h06;
  localparam logic [7:0] OP_CE      = 8'hC7;
  localparam logic [7:0] OP_FREAD   = 8'h0B;
  localparam logic [7:0] OP_PGM_REQ = 8'h11;
  localparam logic [7:0] OP_PP      = 8'h02;

  // Byte counts per field: address, dummy, write, read.
  typedef struct packed {
    logic [7:0] wire_op;
    logic [1:0] a;
    logic [1:0] d;
    logic [2:0] w;
    logic [2:0] r;
    logic       valid;
  } cmd_fields_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CSH   = 2'd2,
    ST_NULL  = 2'd3
  } eng_state_e;

  function automatic logic [47:0] rd_mask(input logic [2:0] r);
    logic [47:0] m;
    case (r)
      3'd1:    m = 48'h0000_0000_00FF;
      3'd2:    m = 48'h0000_0000_FFFF;
      3'd3:    m = 48'h0000_00FF_FFFF;
      3'd4:    m = 48'h0000_FFFF_FFFF;
      3'd5:    m = 48'h00FF_FFFF_FFFF;
      3'd6:    m = 48'hFFFF_FFFF_FFFF;
      default: m = 48'h0000_0000_0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/flash_spi_engine_if.sv
// Request/response bundle between the command decoder and the SPI flash engine.
interface flash_spi_engine_if;
  logic [7:0]  MEMCMD;
  logic [23:0] MEMADDR;
  logic [47:0] MEMVAL;
  logic        MEMTRIG;
  logic        MEMQUAD;
  logic [47:0] MEMDATA;
  logic        MEM_CTRL_busy;

  modport master (
    output MEMCMD, MEMADDR, MEMVAL, MEMTRIG, MEMQUAD,
    input  MEMDATA, MEM_CTRL_busy
  );

  modport slave (
    input  MEMCMD, MEMADDR, MEMVAL, MEMTRIG, MEMQUAD,
    output MEMDATA, MEM_CTRL_busy
  );
endinterface

// File: rtl/flash_cmd_lut.sv
// Combinational map from request opcode to wire opcode and field byte counts;
// unknown opcodes come back with valid cleared.
module flash_cmd_lut
  import flash_cmd_pkg::*;
(
  input  logic [7:0]  op,
  output cmd_fields_t fields
);

  // Opcode decode
  always_comb begin
    fields         = '0;
    fields.wire_op = op;
    fields.valid   = 1'b1;
    case (op)
      OP_RDID:                     fields.r = 3'd6;
      OP_RDSR1, OP_RDSR2, OP_RDCR: fields.r = 3'd1;
      OP_RES: begin
        fields.d = 2'd3;
        fields.r = 3'd1;
      end
      OP_WREN, OP_CE:              fields.valid = 1'b1;
      OP_FREAD: begin
        fields.a = 2'd3;
        fields.d = 2'd1;
        fields.r = 3'd6;
      end
      OP_PGM_REQ: begin
        fields.wire_op = OP_PP;
        fields.a       = 2'd3;
        fields.w       = 3'd6;
      end
      default:                     fields.valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/flash_spi_engine.sv
// Single-lane SPI mode-0 flash transaction engine: serialises one opcode/address/
// dummy/write frame per trigger and captures read bytes into MEMDATA.
module flash_spi_engine
  import flash_cmd_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  flash_spi_engine_if.slave bus,
  output logic              mem_clk,
  output logic              oCS,
  output logic              SI_IO0,
  input  logic              SO_IO1,
  output logic              WP_IO2,
  output logic              HOLD_IO3
);

  localparam logic [15:0] HALF_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] CSH_LAST  = 16'(2 * CLK_DIV - 1);

  // Frame is left-aligned so SI is always the MSB and drains to zero after N bits.
  function automatic logic [87:0] build_tx(input logic [7:0] op, input logic [1:0] a,
                                           input logic [1:0] d, input logic [2:0] w,
                                           input logic [23:0] addr, input logic [47:0] val);
    logic [87:0] tx;
    logic [2:0]  ofs;
    tx  = {op, 80'd0};
    ofs = 3'd1 + {1'b0, a} + {1'b0, d};
    if (a != 2'd0) begin
      tx = tx | {8'd0, addr, 56'd0};
    end else begin
      tx = tx;
    end
    if (w != 3'd0) begin
      tx = tx | ({val, 40'd0} >> {1'b0, ofs, 3'b000});
    end else begin
      tx = tx;
    end
    return tx;
  endfunction

  function automatic logic [6:0] frame_bits(input logic [1:0] a, input logic [1:0] d,
                                            input logic [2:0] w, input logic [2:0] r);
    logic [3:0] bytes;
    bytes = 4'd1 + {2'b00, a} + {2'b00, d} + {1'b0, w} + {1'b0, r};
    return {bytes, 3'b000};
  endfunction

  cmd_fields_t fields_s;
  eng_state_e  state_r, state_s;
  logic [15:0] div_r, div_s;
  logic [6:0]  bit_r, bit_s;
  logic [6:0]  nbits_r, nbits_s;
  logic [2:0]  rlen_r, rlen_s;
  logic [87:0] tx_r, tx_s;
  logic [47:0] rx_r, rx_s;
  logic [47:0] data_r, data_s;
  logic        sck_r, sck_s;
  logic        cs_r, cs_s;
  logic        busy_r, busy_s;

  flash_cmd_lut u_lut (
    .op     (bus.MEMCMD),
    .fields (fields_s)
  );

  // Next-state and next-output logic
  always_comb begin
    state_s = state_r;
    div_s   = div_r;
    bit_s   = bit_r;
    nbits_s = nbits_r;
    rlen_s  = rlen_r;
    tx_s    = tx_r;
    rx_s    = rx_r;
    data_s  = data_r;
    sck_s   = sck_r;
    cs_s    = cs_r;
    busy_s  = busy_r;
    case (state_r)
      ST_IDLE: begin
        busy_s = 1'b0;
        cs_s   = 1'b1;
        sck_s  = 1'b0;
        div_s  = 16'd0;
        bit_s  = 7'd0;
        tx_s   = 88'd0;
        if (bus.MEMTRIG) begin
          busy_s = 1'b1;
          if (fields_s.valid) begin
            state_s = ST_SHIFT;
            cs_s    = 1'b0;
            tx_s    = build_tx(fields_s.wire_op, fields_s.a, fields_s.d, fields_s.w,
                               bus.MEMADDR, bus.MEMVAL);
            rx_s    = 48'd0;
            nbits_s = frame_bits(fields_s.a, fields_s.d, fields_s.w, fields_s.r);
            rlen_s  = fields_s.r;
          end else begin
            state_s = ST_NULL;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (div_r == HALF_LAST) begin
          div_s = 16'd0;
          if (!sck_r) begin
            sck_s = 1'b1;
            rx_s  = {rx_r[46:0], SO_IO1};
          end else begin
            sck_s = 1'b0;
            tx_s  = {tx_r[86:0], 1'b0};
            if (bit_r == nbits_r - 7'd1) begin
              state_s = ST_CSH;
              cs_s    = 1'b1;
              bit_s   = 7'd0;
            end else begin
              bit_s = bit_r + 7'd1;
            end
          end
        end else begin
          div_s = div_r + 16'd1;
        end
      end
      ST_CSH: begin
        if (div_r == CSH_LAST) begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
          div_s   = 16'd0;
          if (rlen_r != 3'd0) begin
            data_s = rx_r & rd_mask(rlen_r);
          end else begin
            data_s = data_r;
          end
        end else begin
          div_s = div_r + 16'd1;
        end
      end
      ST_NULL: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
        cs_s    = 1'b1;
        sck_s   = 1'b0;
        tx_s    = 88'd0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= ST_IDLE;
      div_r   <= 16'd0;
      bit_r   <= 7'd0;
      nbits_r <= 7'd0;
      rlen_r  <= 3'd0;
      tx_r    <= 88'd0;
      rx_r    <= 48'd0;
      data_r  <= 48'd0;
      sck_r   <= 1'b0;
      cs_r    <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      div_r   <= div_s;
      bit_r   <= bit_s;
      nbits_r <= nbits_s;
      rlen_r  <= rlen_s;
      tx_r    <= tx_s;
      rx_r    <= rx_s;
      data_r  <= data_s;
      sck_r   <= sck_s;
      cs_r    <= cs_s;
      busy_r  <= busy_s;
    end
  end

  assign mem_clk           = sck_r;
  assign oCS               = cs_r;
  assign SI_IO0            = tx_r[87];
  assign WP_IO2            = 1'b1;
  assign HOLD_IO3          = 1'b1;
  assign bus.MEMDATA       = data_r;
  assign bus.MEM_CTRL_busy = busy_r;

endmodule

// File: tb/tb_flash_spi_engine.sv
// Directed bench for flash_spi_engine with a behavioural SPI flash responder.
module tb_flash_spi_engine;

  logic CLK = 1'b0;
  logic RST_N;
  logic mem_clk, oCS, SI_IO0, WP_IO2, HOLD_IO3;
  logic so;

  flash_spi_engine_if bus_if ();

  flash_spi_engine #(.CLK_DIV(2)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .bus      (bus_if),
    .mem_clk  (mem_clk),
    .oCS      (oCS),
    .SI_IO0   (SI_IO0),
    .SO_IO1   (so),
    .WP_IO2   (WP_IO2),
    .HOLD_IO3 (HOLD_IO3)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  // Flash-side observers: SCK rises, shifted-in SI bits, chip-select falls
  int          rises = 0;
  int          cs_falls = 0;
  int          bit_idx = 0;
  logic [87:0] si_sh = 88'd0;
  logic [47:0] resp_l = 48'd0;
  int          rd_start = 0;
  int          rd_len = 0;

  always @(posedge mem_clk) begin
    rises <= rises + 1;
    si_sh <= {si_sh[86:0], SI_IO0};
  end

  always @(negedge mem_clk or posedge oCS) begin
    if (oCS) bit_idx <= 0;
    else     bit_idx <= bit_idx + 1;
  end

  always @(negedge oCS) cs_falls <= cs_falls + 1;

  // Flash drives read bits during the read window, 1 elsewhere
  always_comb begin
    so = 1'b1;
    if (bit_idx >= rd_start && bit_idx < rd_start + rd_len) so = resp_l[6'(47 - (bit_idx - rd_start))];
    else so = 1'b1;
  end

  task automatic check(input string tag, input logic [87:0] obs, input logic [87:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents a request at the t0 edge; returns #1 into cycle t0+1
  task automatic start(input logic [7:0] op, input logic [23:0] addr, input logic [47:0] val, input bit keep);
    @(negedge CLK);
    bus_if.MEMCMD  = op;
    bus_if.MEMADDR = addr;
    bus_if.MEMVAL  = val;
    bus_if.MEMTRIG = 1'b1;
    @(posedge CLK);
    #1;
    if (!keep) bus_if.MEMTRIG = 1'b0;
  endtask

  // Cycle numbers relative to t0 of busy fall and of oCS rise
  task automatic wait_done(output int done_cyc, output int cs_cyc);
    done_cyc = 1;
    cs_cyc = 0;
    while (bus_if.MEM_CTRL_busy === 1'b1 && done_cyc < 500) begin
      @(posedge CLK);
      #1;
      done_cyc++;
      if (cs_cyc == 0 && oCS === 1'b1) cs_cyc = done_cyc;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0, c0, dc, cc, gap, cyc;
    bit second_low;

    RST_N = 1'b0;
    bus_if.MEMCMD = 8'h00;
    bus_if.MEMADDR = 24'h0;
    bus_if.MEMVAL = 48'h0;
    bus_if.MEMTRIG = 1'b0;
    bus_if.MEMQUAD = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_cs", oCS, 1'b1);
    check("rst_sck", mem_clk, 1'b0);
    check("rst_si", SI_IO0, 1'b0);
    check("rst_busy", bus_if.MEM_CTRL_busy, 1'b0);
    check("rst_data", bus_if.MEMDATA, 48'h0);
    check("rst_wp", WP_IO2, 1'b1);
    check("rst_hold", HOLD_IO3, 1'b1);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    // RDID
    resp_l = 48'h0120184D0180; rd_start = 8; rd_len = 48;
    r0 = rises;
    start(8'h9F, 24'h0, 48'h0, 1'b0);
    check("rdid_t1_busy", bus_if.MEM_CTRL_busy, 1'b1);
    check("rdid_t1_cs", oCS, 1'b0);
    check("rdid_t1_si", SI_IO0, 1'b1);
    wait_done(dc, cc);
    check("rdid_rises", 88'(rises - r0), 88'd56);
    check("rdid_data", bus_if.MEMDATA, 48'h0120184D0180);
    check("rdid_busy_fall", 88'(dc), 88'd229);
    check("rdid_cs_rise", 88'(cc), 88'd225);
    check("rdid_op_bits", si_sh[55:48], 8'h9F);

    // RDSR1
    resp_l = 48'h030000000000; rd_start = 8; rd_len = 8;
    r0 = rises;
    start(8'h05, 24'h0, 48'h0, 1'b0);
    wait_done(dc, cc);
    check("rdsr1_rises", 88'(rises - r0), 88'd16);
    check("rdsr1_data", bus_if.MEMDATA, 48'h000000000003);
    check("rdsr1_busy_fall", 88'(dc), 88'd69);

    // Page program
    rd_len = 0;
    r0 = rises;
    start(8'h11, 24'h012345, 48'hA1A2A3A4A5A6, 1'b0);
    check("pp_t1_si", SI_IO0, 1'b0);
    wait_done(dc, cc);
    check("pp_rises", 88'(rises - r0), 88'd80);
    check("pp_si_bytes", si_sh[79:0], 80'h02012345A1A2A3A4A5A6);
    check("pp_data_kept", bus_if.MEMDATA, 48'h000000000003);
    check("pp_busy_fall", 88'(dc), 88'd325);

    // Fast read, MEMQUAD set to show it is ignored
    resp_l = 48'h112233445566; rd_start = 40; rd_len = 48;
    bus_if.MEMQUAD = 1'b1;
    r0 = rises;
    start(8'h0B, 24'h000100, 48'h0, 1'b0);
    wait_done(dc, cc);
    bus_if.MEMQUAD = 1'b0;
    check("fread_rises", 88'(rises - r0), 88'd88);
    check("fread_si_bytes", si_sh, 88'h0B000100000000000000_00);
    check("fread_data", bus_if.MEMDATA, 48'h112233445566);
    check("fread_busy_fall", 88'(dc), 88'd357);

    // Null request
    rd_len = 0;
    c0 = cs_falls;
    start(8'h55, 24'h0, 48'h0, 1'b0);
    check("null_t1_busy", bus_if.MEM_CTRL_busy, 1'b1);
    check("null_t1_cs", oCS, 1'b1);
    @(posedge CLK); #1;
    check("null_t2_busy", bus_if.MEM_CTRL_busy, 1'b0);
    check("null_cs_falls", 88'(cs_falls - c0), 88'd0);
    check("null_data_kept", bus_if.MEMDATA, 48'h112233445566);

    // WREN with trigger held for 20 cycles
    c0 = cs_falls; r0 = rises;
    start(8'h06, 24'h0, 48'h0, 1'b1);
    for (int i = 1; i < 60; i++) begin
      if (i == 20) bus_if.MEMTRIG = 1'b0;
      @(posedge CLK); #1;
    end
    check("wren_cs_falls", 88'(cs_falls - c0), 88'd1);
    check("wren_rises", 88'(rises - r0), 88'd8);
    check("wren_busy", bus_if.MEM_CTRL_busy, 1'b0);

    // Back-to-back WREN with trigger held: minimum deselect gap
    c0 = cs_falls; r0 = rises;
    gap = 0; second_low = 1'b0;
    start(8'h06, 24'h0, 48'h0, 1'b1);
    for (int i = 0; i < 80; i++) begin
      if (!second_low && oCS === 1'b1) gap++;
      else if (!second_low && oCS === 1'b0 && gap > 0) begin
        second_low = 1'b1;
        bus_if.MEMTRIG = 1'b0;
      end
      @(posedge CLK); #1;
    end
    bus_if.MEMTRIG = 1'b0;
    wait_done(dc, cc);
    check("b2b_gap", 88'(gap), 88'd5);
    check("b2b_cs_falls", 88'(cs_falls - c0), 88'd2);
    check("b2b_rises", 88'(rises - r0), 88'd16);

    // Reset during RDID at bit 30
    resp_l = 48'h0120184D0180; rd_start = 8; rd_len = 48;
    r0 = rises;
    start(8'h9F, 24'h0, 48'h0, 1'b0);
    cyc = 0;
    while ((rises - r0) < 30 && cyc < 400) begin
      @(negedge CLK);
      cyc++;
    end
    check("mid_reached_bit30", 88'(rises - r0), 88'd30);
    RST_N = 1'b0;
    #1;
    check("mid_cs", oCS, 1'b1);
    check("mid_sck", mem_clk, 1'b0);
    check("mid_busy", bus_if.MEM_CTRL_busy, 1'b0);
    check("mid_data", bus_if.MEMDATA, 48'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    resp_l = 48'h030000000000; rd_start = 8; rd_len = 8;
    r0 = rises;
    start(8'h05, 24'h0, 48'h0, 1'b0);
    wait_done(dc, cc);
    check("post_rst_rises", 88'(rises - r0), 88'd16);
    check("post_rst_data", bus_if.MEMDATA, 48'h000000000003);
    check("post_rst_busy_fall", 88'(dc), 88'd69);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
